// File: rtl/iter_norm_shift_pkg.sv
// Shared configuration for the iterative normalization shifter:
// datapath width, shift-amount width and per-cycle shift step.
package iter_norm_shift_pkg;

  localparam int NORMSHIFTSZ    = 64;
  localparam int LOGNORMSHIFTSZ = 7;
  localparam int NORMSTEPLOG    = 3;

endpackage

// File: rtl/iter_norm_shift_step.sv
// One shift step: shifts left by k = min(rem, 2^STEPLOG) and reports the
// remaining count plus whether the shifted value became all-zero.
module norm_step_shift #(
  parameter int N       = 64,
  parameter int L       = 7,
  parameter int STEPLOG = 3
) (
  input  logic [N-1:0] a,
  input  logic [L-1:0] rem,
  output logic [N-1:0] y,
  output logic [L-1:0] rem_left,
  output logic         zero
);

  localparam int STEP = 1 << STEPLOG;

  // One extra bit so STEP still fits when STEPLOG == L.
  logic [L:0] rem_ext;
  logic [L:0] step_ext;
  logic [L:0] k;

  assign rem_ext  = {1'b0, rem};
  assign step_ext = (L+1)'(STEP);
  assign k        = (rem_ext >= step_ext) ? step_ext : rem_ext;

  assign y        = a << k;
  assign rem_left = rem - k[L-1:0];
  assign zero     = (y == '0);

endmodule

// File: rtl/iter_norm_shift.sv
// Multi-cycle left normalization shifter: shifts at most 2^STEPLOG bits per
// cycle, with ready/valid on both sides and flush abandoning the operation.
module iter_norm_shift
  import iter_norm_shift_pkg::*;
#(
  parameter int N       = NORMSHIFTSZ,
  parameter int L       = LOGNORMSHIFTSZ,
  parameter int STEPLOG = NORMSTEPLOG
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         FlushE,
  input  logic         InValid,
  output logic         InReady,
  input  logic [N-1:0] ShiftIn,
  input  logic [L-1:0] ShiftAmt,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [N-1:0] Shifted,
  output logic         ZeroRes
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       state_reg, state_next;
  logic [N-1:0] acc_reg, acc_next;
  logic [L-1:0] rem_reg, rem_next;
  logic [N-1:0] shifted_reg;
  logic         zero_reg;
  logic         load_out;

  logic [N-1:0] step_y;
  logic [L-1:0] step_rem;
  logic         step_zero;

  norm_step_shift #(
    .N       (N),
    .L       (L),
    .STEPLOG (STEPLOG)
  ) u_step (
    .a        (acc_reg),
    .rem      (rem_reg),
    .y        (step_y),
    .rem_left (step_rem),
    .zero     (step_zero)
  );

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    rem_next   = rem_reg;
    load_out   = 1'b0;
    if (FlushE) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (InValid) begin
            acc_next = ShiftIn;
            rem_next = ShiftAmt;
            if (ShiftAmt == '0 || ShiftIn == '0) begin
              state_next = DONE;
              load_out   = 1'b1;
            end else begin
              state_next = SHIFT;
            end
          end
        end
        SHIFT: begin
          acc_next = step_y;
          rem_next = step_rem;
          if (step_rem == '0 || step_zero) begin
            state_next = DONE;
            load_out   = 1'b1;
          end
        end
        DONE: begin
          if (OutReady) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output registers are captured on entry to DONE so they stay stable
  // for the whole time the consumer applies backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      rem_reg     <= '0;
      shifted_reg <= '0;
      zero_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      rem_reg   <= rem_next;
      if (load_out) begin
        shifted_reg <= acc_next;
        zero_reg    <= (acc_next == '0);
      end
    end
  end

  assign InReady  = (state_reg == IDLE);
  assign OutValid = (state_reg == DONE);
  assign Shifted  = shifted_reg;
  assign ZeroRes  = zero_reg;

endmodule

// File: tb/tb_iter_norm_shift.sv
// Directed bench for iter_norm_shift (N=64, L=7, STEP=8) with hand-computed
// expected latencies and results.
module tb_iter_norm_shift;

  localparam int N = 64;
  localparam int L = 7;

  logic         clk = 1'b0;
  logic         reset;
  logic         FlushE;
  logic         InValid;
  logic         InReady;
  logic [N-1:0] ShiftIn;
  logic [L-1:0] ShiftAmt;
  logic         OutValid;
  logic         OutReady;
  logic [N-1:0] Shifted;
  logic         ZeroRes;

  int checks   = 0;
  int failures = 0;

  iter_norm_shift dut (
    .clk      (clk),
    .reset    (reset),
    .FlushE   (FlushE),
    .InValid  (InValid),
    .InReady  (InReady),
    .ShiftIn  (ShiftIn),
    .ShiftAmt (ShiftAmt),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Shifted  (Shifted),
    .ZeroRes  (ZeroRes)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one operation and waits for OutValid; leaves the DUT in DONE.
  task automatic run_op(input string tag, input logic [N-1:0] din, input logic [L-1:0] amt,
                        input int exp_lat, input logic [N-1:0] exp_sh, input logic exp_z);
    int cyc;
    expect_eq({tag, " ready"}, 64'(InReady), 64'd1);
    ShiftIn  = din;
    ShiftAmt = amt;
    InValid  = 1'b1;
    tick();
    InValid = 1'b0;
    cyc = 1;
    while (!OutValid && cyc < 200) begin
      tick();
      cyc++;
    end
    expect_eq({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    expect_eq({tag, " shifted"}, Shifted, exp_sh);
    expect_eq({tag, " zero"}, 64'(ZeroRes), 64'(exp_z));
  endtask

  task automatic drain(input string tag);
    OutReady = 1'b1;
    tick();
    expect_eq({tag, " idle_ready"}, 64'(InReady), 64'd1);
    expect_eq({tag, " idle_valid"}, 64'(OutValid), 64'd0);
  endtask

  initial begin
    reset    = 1'b1;
    FlushE   = 1'b0;
    InValid  = 1'b0;
    ShiftIn  = '0;
    ShiftAmt = '0;
    OutReady = 1'b1;
    tick();
    tick();
    expect_eq("rst ready", 64'(InReady), 64'd1);
    expect_eq("rst valid", 64'(OutValid), 64'd0);
    expect_eq("rst shifted", Shifted, 64'd0);
    expect_eq("rst zero", 64'(ZeroRes), 64'd0);
    reset = 1'b0;
    tick();

    // 19 = 8 + 8 + 3: three shift cycles, valid in cycle 4
    run_op("amt19", 64'd1 << 44, 7'd19, 4, 64'h8000_0000_0000_0000, 1'b0);
    drain("amt19");

    run_op("amt0", 64'hA500_0000_0000_0000, 7'd0, 1, 64'hA500_0000_0000_0000, 1'b0);
    drain("amt0");

    run_op("zero_in", 64'd0, 7'd40, 1, 64'd0, 1'b1);
    drain("zero_in");

    run_op("amt13", 64'h3, 7'd13, 3, 64'h6000, 1'b0);
    drain("amt13");

    // All-ones shifted by exactly N: eight full steps
    run_op("amt64", 64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 9, 64'd0, 1'b1);
    drain("amt64");

    // Backpressure: held outputs, ignored InValid pulses
    OutReady = 1'b0;
    run_op("bp", 64'h1, 7'd5, 2, 64'h20, 1'b0);
    for (int i = 0; i < 5; i++) begin
      InValid  = (i % 2 == 0);
      ShiftIn  = 64'hDEAD;
      ShiftAmt = 7'd2;
      tick();
      expect_eq("bp hold_valid", 64'(OutValid), 64'd1);
      expect_eq("bp hold_shifted", Shifted, 64'h20);
      expect_eq("bp hold_ready", 64'(InReady), 64'd0);
    end
    InValid = 1'b0;
    drain("bp");

    // Flush in the second SHIFT cycle of a 30-bit shift
    ShiftIn  = 64'h1;
    ShiftAmt = 7'd30;
    InValid  = 1'b1;
    tick();
    InValid = 1'b0;
    tick();
    FlushE = 1'b1;
    tick();
    FlushE = 1'b0;
    expect_eq("flush ready", 64'(InReady), 64'd1);
    expect_eq("flush valid", 64'(OutValid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_eq("flush no_valid", 64'(OutValid), 64'd0);
    end
    run_op("post_flush", 64'h5, 7'd1, 2, 64'hA, 1'b0);
    drain("post_flush");

    // Reset mid-SHIFT together with InValid
    ShiftIn  = 64'h1;
    ShiftAmt = 7'd40;
    InValid  = 1'b1;
    tick();
    tick();
    reset   = 1'b1;
    ShiftIn = 64'h77;
    tick();
    expect_eq("rst_mid ready", 64'(InReady), 64'd1);
    expect_eq("rst_mid valid", 64'(OutValid), 64'd0);
    expect_eq("rst_mid shifted", Shifted, 64'd0);
    expect_eq("rst_mid zero", 64'(ZeroRes), 64'd0);
    reset   = 1'b0;
    InValid = 1'b0;
    tick();
    expect_eq("rst_mid no_accept", 64'(InReady), 64'd1);

    // N+3: zero after eight steps, one cycle before the nominal latency
    run_op("amt67", 64'h1, 7'd67, 9, 64'd0, 1'b1);
    drain("amt67");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iter_norm_shift.md
Name: iter_norm_shift

Overview:
- Multi-cycle normalization shifter for the FPU post-processing path. Sits between the LZA/shift-amount logic and the shift-correction stage, and produces the Shifted operand that stage consumes.
- Takes a pre-normalized sum or quotient and a left-shift amount. It shifts at most 2^STEPLOG bits per cycle instead of using a full single-cycle barrel shifter, trading latency for area in small FPU configurations.
- Uses ready/valid handshakes on both sides, and honours pipeline flush.

Parameters:
- P, (none; cvw_t configuration), supplies NORMSHIFTSZ (datapath width N) and LOGNORMSHIFTSZ (shift-amount width L).
- STEPLOG, 3, log2 of the maximum shift per cycle; STEP = 2^STEPLOG; legal range 1..L.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- FlushE  in  1  pipeline flush; abandons any operation in progress
- InValid  in  1  ShiftIn/ShiftAmt valid
- InReady  out  1  block can accept; combinational, equals (State==IDLE)
- ShiftIn  in  N  unnormalized significand, MSB-aligned as for the single-cycle shifter
- ShiftAmt  in  L  left-shift amount from the LZA, including the LZA's possible +1 error (not corrected here)
- OutValid  out  1  Shifted is final
- OutReady  in  1  consumer accepts Shifted
- Shifted  out  N  ShiftIn << ShiftAmt, zero-filled, truncated to N bits
- ZeroRes  out  1  accumulator was all-zero at completion

Behaviour:
- Reset state: State=IDLE, OutValid=0, Shifted=0, ZeroRes=0, remaining count Rem=0.
- States: IDLE, SHIFT, DONE. InReady is asserted only in IDLE.
- IDLE, accept (InValid & InReady & ~FlushE):
  - Acc<=ShiftIn; Rem<=ShiftAmt.
  - If ShiftAmt==0 or ShiftIn==0, go to DONE; otherwise go to SHIFT.
- SHIFT, each cycle:
  - k = min(Rem, STEP); Acc<=Acc<<k; Rem<=Rem-k.
  - Go to DONE when Rem-k==0, or when (Acc<<k)==0 (early zero exit).
  - Rem never underflows. Arithmetic is unsigned, L bits wide.
- DONE:
  - OutValid=1. Shifted=Acc, ZeroRes=(Acc==0); both registered and held stable while OutValid & ~OutReady.
  - OutReady: go to IDLE and drop OutValid on the next edge. No accept occurs in the same cycle as the output handshake; the minimum issue interval is latency+1.
- Latency: OutValid is high in the cycle ceil(ShiftAmt/STEP)+1 after the accept cycle. The accept edge counts as cycle 0 → cycle 1 when ShiftAmt=0. Early zero exit shortens this.
- Shift amounts ≥ N: the result is all-zero and ZeroRes=1, reached at the latest after ceil(N/STEP) shift cycles.
- FlushE, in any state: next state IDLE, OutValid=0. Shifted and ZeroRes retain their values and are don't-care. Flush has priority over both accept and OutReady in the same cycle.
- Reset mid-operation: identical to the reset state on the next edge. The partially shifted Acc is discarded.
- InValid while not ready: ignored. The producer must hold its inputs until accepted.
- Acc and Rem are loaded only on accept or during SHIFT; they do not change in DONE or IDLE.

Decomposition:
- cvw package: STEPLOG added to cvw_t as NORMSTEPLOG; the per-config default is set in the config files. NORMSHIFTSZ and LOGNORMSHIFTSZ already live there.
- State enum (IDLE/SHIFT/DONE) is local to the module.
- One combinational sub-module, norm_step_shift: shifts its input left by 0..STEP bits and computes the k=min(Rem,STEP) select. State and Acc/Rem registers use the existing flopenr/flopr primitives.

Test Plan (N=P.NORMSHIFTSZ, STEP=8):
- ShiftIn=1<<(N-20), ShiftAmt=19, OutReady=1 → shift steps 8, 8, 3; OutValid in cycle 4 after accept; Shifted=1<<(N-1); ZeroRes=0; InReady returns in cycle 5.
- ShiftAmt=0, ShiftIn=0xA5 in the top byte → OutValid in cycle 1; Shifted==ShiftIn; exactly one cycle of InReady=0 before DONE.
- ShiftIn=0, ShiftAmt=40 → early exit: OutValid in cycle 1; Shifted=0; ZeroRes=1.
- Backpressure: hold OutReady=0 for 5 cycles in DONE → Shifted/OutValid stable, InValid pulses ignored; OutReady=1 → IDLE next edge.
- FlushE in the 2nd SHIFT cycle of a ShiftAmt=30 op → IDLE next edge, OutValid never asserted; a following op with ShiftAmt=1 completes correctly.
- reset asserted mid-SHIFT together with InValid → all outputs at reset values next edge, no accept; post-reset op with ShiftAmt=N+3 → Shifted=0, ZeroRes=1.
